// File: rtl/three_port_ram_ctrl.sv
// Controller for a 1W/2R synchronous RAM: clear after reset or flush,
// round-robin write arbitration, and write-first read forwarding.
module three_port_ram_ctrl #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_DEPTH = 1024,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  FlushReq_SI,
    output logic                  Busy_SO,

    input  logic                  Wr0Valid_SI,
    output logic                  Wr0Ready_SO,
    input  logic [ADDR_WIDTH-1:0] Wr0Addr_DI,
    input  logic [DATA_WIDTH-1:0] Wr0Data_DI,
    input  logic                  Wr1Valid_SI,
    output logic                  Wr1Ready_SO,
    input  logic [ADDR_WIDTH-1:0] Wr1Addr_DI,
    input  logic [DATA_WIDTH-1:0] Wr1Data_DI,

    input  logic                  Rd0Valid_SI,
    output logic                  Rd0Ready_SO,
    input  logic [ADDR_WIDTH-1:0] Rd0Addr_DI,
    output logic                  Rd0RespValid_SO,
    output logic [DATA_WIDTH-1:0] Rd0Data_DO,
    input  logic                  Rd1Valid_SI,
    output logic                  Rd1Ready_SO,
    input  logic [ADDR_WIDTH-1:0] Rd1Addr_DI,
    output logic                  Rd1RespValid_SO,
    output logic [DATA_WIDTH-1:0] Rd1Data_DO,

    output logic                  RamWrEn_SO,
    output logic [ADDR_WIDTH-1:0] RamWrAddr_DO,
    output logic [DATA_WIDTH-1:0] RamWrData_DO,
    output logic [ADDR_WIDTH-1:0] RamRdAddr0_DO,
    output logic [ADDR_WIDTH-1:0] RamRdAddr1_DO,
    input  logic [DATA_WIDTH-1:0] RamRdData0_DI,
    input  logic [DATA_WIDTH-1:0] RamRdData1_DI
);

    typedef enum logic [1:0] {
        INIT,
        CLEAR,
        RUN
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  rr_ptr_q, rr_ptr_d;

    logic                  run;
    logic                  clearing;
    logic                  gnt0, gnt1;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    logic                  hs0, hs1;
    logic                  hit0, hit1;
    logic                  resp0_q, resp1_q;
    logic                  fwd0_q, fwd1_q;
    logic [DATA_WIDTH-1:0] fwd0_data_q, fwd1_data_q;

    assign run      = (state_q == RUN);
    assign clearing = (state_q == CLEAR);
    assign Busy_SO  = ~run;

    // State and clear counter
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q   <= INIT;
            clr_cnt_q <= '0;
            rr_ptr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            INIT: begin
                state_d   = CLEAR;
                clr_cnt_d = '0;
            end
            CLEAR: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                end
            end
            RUN: begin
                if (FlushReq_SI) begin
                    state_d = INIT;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Round-robin write arbitration; the pointer names the favoured requester
    assign gnt0 = run & Wr0Valid_SI & (~Wr1Valid_SI | ~rr_ptr_q);
    assign gnt1 = run & Wr1Valid_SI & (~Wr0Valid_SI |  rr_ptr_q);

    assign Wr0Ready_SO = gnt0;
    assign Wr1Ready_SO = gnt1;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt0) begin
            rr_ptr_d = 1'b1;
        end else if (gnt1) begin
            rr_ptr_d = 1'b0;
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        unique case (1'b1)
            clearing: begin
                wr_en   = 1'b1;
                wr_addr = clr_cnt_q;
                wr_data = INIT_VALUE;
            end
            gnt0: begin
                wr_en   = 1'b1;
                wr_addr = Wr0Addr_DI;
                wr_data = Wr0Data_DI;
            end
            gnt1: begin
                wr_en   = 1'b1;
                wr_addr = Wr1Addr_DI;
                wr_data = Wr1Data_DI;
            end
            default: ;
        endcase
    end

    assign RamWrEn_SO   = wr_en;
    assign RamWrAddr_DO = wr_addr;
    assign RamWrData_DO = wr_data;

    // Read request side
    assign Rd0Ready_SO   = run;
    assign Rd1Ready_SO   = run;
    assign RamRdAddr0_DO = run ? Rd0Addr_DI : '0;
    assign RamRdAddr1_DO = run ? Rd1Addr_DI : '0;

    assign hs0  = run & Rd0Valid_SI;
    assign hs1  = run & Rd1Valid_SI;
    assign hit0 = hs0 & (gnt0 | gnt1) & (wr_addr == Rd0Addr_DI);
    assign hit1 = hs1 & (gnt0 | gnt1) & (wr_addr == Rd1Addr_DI);

    // RAM is read-first, so a colliding write must be replayed from here
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            resp0_q     <= 1'b0;
            resp1_q     <= 1'b0;
            fwd0_q      <= 1'b0;
            fwd1_q      <= 1'b0;
            fwd0_data_q <= '0;
            fwd1_data_q <= '0;
        end else begin
            resp0_q <= hs0;
            resp1_q <= hs1;
            fwd0_q  <= hit0;
            fwd1_q  <= hit1;
            if (hit0) begin
                fwd0_data_q <= wr_data;
            end
            if (hit1) begin
                fwd1_data_q <= wr_data;
            end
        end
    end

    assign Rd0RespValid_SO = resp0_q;
    assign Rd1RespValid_SO = resp1_q;

    always_comb begin
        Rd0Data_DO = '0;
        Rd1Data_DO = '0;
        if (resp0_q) begin
            Rd0Data_DO = fwd0_q ? fwd0_data_q : RamRdData0_DI;
        end
        if (resp1_q) begin
            Rd1Data_DO = fwd1_q ? fwd1_data_q : RamRdData1_DI;
        end
    end

endmodule

// File: tb/tb_three_port_ram_ctrl.sv
// Directed bench for three_port_ram_ctrl with a behavioural
// read-first 1W/2R RAM attached to the RAM-side ports.
module tb_three_port_ram_ctrl;

    localparam int unsigned AW = 4;
    localparam int unsigned DD = 16;
    localparam int unsigned DW = 32;
    localparam logic [DW-1:0] INIT = 32'hC0DE_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          busy;
    logic          wr0_v = 1'b0, wr1_v = 1'b0;
    logic          wr0_r, wr1_r;
    logic [AW-1:0] wr0_a = '0, wr1_a = '0;
    logic [DW-1:0] wr0_d = '0, wr1_d = '0;
    logic          rd0_v = 1'b0, rd1_v = 1'b0;
    logic          rd0_r, rd1_r;
    logic [AW-1:0] rd0_a = '0, rd1_a = '0;
    logic          rsp0_v, rsp1_v;
    logic [DW-1:0] rsp0_d, rsp1_d;
    logic          ram_we;
    logic [AW-1:0] ram_wa, ram_ra0, ram_ra1;
    logic [DW-1:0] ram_wd, ram_rd0, ram_rd1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    three_port_ram_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_DEPTH(DD),
        .DATA_WIDTH(DW),
        .INIT_VALUE(INIT)
    ) dut (
        .Clk_CI(clk),
        .Rst_RBI(rst_n),
        .FlushReq_SI(flush),
        .Busy_SO(busy),
        .Wr0Valid_SI(wr0_v),
        .Wr0Ready_SO(wr0_r),
        .Wr0Addr_DI(wr0_a),
        .Wr0Data_DI(wr0_d),
        .Wr1Valid_SI(wr1_v),
        .Wr1Ready_SO(wr1_r),
        .Wr1Addr_DI(wr1_a),
        .Wr1Data_DI(wr1_d),
        .Rd0Valid_SI(rd0_v),
        .Rd0Ready_SO(rd0_r),
        .Rd0Addr_DI(rd0_a),
        .Rd0RespValid_SO(rsp0_v),
        .Rd0Data_DO(rsp0_d),
        .Rd1Valid_SI(rd1_v),
        .Rd1Ready_SO(rd1_r),
        .Rd1Addr_DI(rd1_a),
        .Rd1RespValid_SO(rsp1_v),
        .Rd1Data_DO(rsp1_d),
        .RamWrEn_SO(ram_we),
        .RamWrAddr_DO(ram_wa),
        .RamWrData_DO(ram_wd),
        .RamRdAddr0_DO(ram_ra0),
        .RamRdAddr1_DO(ram_ra1),
        .RamRdData0_DI(ram_rd0),
        .RamRdData1_DI(ram_rd1)
    );

    logic [DW-1:0] mem [DD];

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_wd;
        ram_rd0 <= mem[ram_ra0];
        ram_rd1 <= mem[ram_ra1];
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 of the INIT cycle; returns inside the first RUN cycle
    task automatic clear_seq(input int flush_at);
        for (int i = 0; i <= int'(DD); i++) begin
            if (i > 0) tick();
            if (i == 0) begin
                wr0_v = 1'b1; wr0_a = 4'hE; wr0_d = 32'h1234;
                rd0_v = 1'b1; rd0_a = 4'h3;
            end
            flush = (i == flush_at);
            #1;
            chk("clr_busy", 64'(busy), 64'd1);
            chk("clr_wr0_ready", 64'(wr0_r), 64'd0);
            chk("clr_rd0_ready", 64'(rd0_r), 64'd0);
            chk("clr_rd_addr0", 64'(ram_ra0), 64'd0);
            if (i == 0) begin
                chk("init_we", 64'(ram_we), 64'd0);
                chk("init_waddr", 64'(ram_wa), 64'd0);
            end else begin
                chk("clr_we", 64'(ram_we), 64'd1);
                chk("clr_waddr", 64'(ram_wa), 64'(i - 1));
                chk("clr_wdata", 64'(ram_wd), 64'(INIT));
            end
        end
        flush = 1'b0;
        wr0_v = 1'b0;
        rd0_v = 1'b0;
        tick();
        #1;
        chk("run_busy", 64'(busy), 64'd0);
        chk("run_rd0_ready", 64'(rd0_r), 64'd1);
        chk("run_rd1_ready", 64'(rd1_r), 64'd1);
        chk("run_idle_we", 64'(ram_we), 64'd0);
        chk("run_idle_waddr", 64'(ram_wa), 64'd0);
        chk("run_idle_wdata", 64'(ram_wd), 64'd0);
    endtask

    initial begin
        wr0_v = 1'b1; wr0_a = 4'h9;
        rd0_v = 1'b1; rd0_a = 4'h5;
        #2;
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_wr0_ready", 64'(wr0_r), 64'd0);
        chk("rst_rd0_ready", 64'(rd0_r), 64'd0);
        chk("rst_we", 64'(ram_we), 64'd0);
        chk("rst_waddr", 64'(ram_wa), 64'd0);
        chk("rst_rd_addr0", 64'(ram_ra0), 64'd0);
        chk("rst_resp0", 64'(rsp0_v), 64'd0);
        chk("rst_data0", 64'(rsp0_d), 64'd0);
        wr0_v = 1'b0; rd0_v = 1'b0;

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_seq(-1);

        // Both writers valid: grants alternate 0,1,0,1
        tick();
        wr0_v = 1'b1; wr0_a = 4'd3; wr0_d = 32'h3030;
        wr1_v = 1'b1; wr1_a = 4'd5; wr1_d = 32'h5050;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            #1;
            chk("rr_wr0_ready", 64'(wr0_r), 64'(k % 2 == 0));
            chk("rr_wr1_ready", 64'(wr1_r), 64'(k % 2 == 1));
            chk("rr_we", 64'(ram_we), 64'd1);
            chk("rr_waddr", 64'(ram_wa), (k % 2 == 0) ? 64'd3 : 64'd5);
            chk("rr_wdata", 64'(ram_wd), (k % 2 == 0) ? 64'h3030 : 64'h5050);
        end
        tick();
        wr0_v = 1'b0;
        #1;
        chk("solo_wr1_ready", 64'(wr1_r), 64'd1);
        chk("solo_wr0_ready", 64'(wr0_r), 64'd0);
        chk("solo_waddr", 64'(ram_wa), 64'd5);

        // Same-cycle write and dual read of address 7
        tick();
        wr1_v = 1'b0;
        wr0_v = 1'b1; wr0_a = 4'd7; wr0_d = 32'hDEADBEEF;
        rd0_v = 1'b1; rd0_a = 4'd7;
        rd1_v = 1'b1; rd1_a = 4'd7;
        #1;
        chk("fwd_rd0_ready", 64'(rd0_r), 64'd1);
        chk("fwd_rd_addr1", 64'(ram_ra1), 64'd7);
        chk("fwd_we", 64'(ram_we), 64'd1);
        tick();
        wr0_v = 1'b1; wr0_a = 4'd4; wr0_d = 32'h11;
        rd0_v = 1'b0;
        rd1_v = 1'b1; rd1_a = 4'd7;
        #1;
        chk("fwd_resp0", 64'(rsp0_v), 64'd1);
        chk("fwd_data0", 64'(rsp0_d), 64'hDEADBEEF);
        chk("fwd_resp1", 64'(rsp1_v), 64'd1);
        chk("fwd_data1", 64'(rsp1_d), 64'hDEADBEEF);

        tick();
        wr0_v = 1'b0; rd1_v = 1'b0;
        rd0_v = 1'b1; rd0_a = 4'd4;
        #1;
        chk("nofwd_resp0_idle", 64'(rsp0_v), 64'd0);
        chk("ram_resp1", 64'(rsp1_v), 64'd1);
        chk("ram_data1", 64'(rsp1_d), 64'hDEADBEEF);

        // Write 0x22 to 4 while port 1 reads 5: no forward on address mismatch
        tick();
        rd0_v = 1'b0;
        wr0_v = 1'b1; wr0_a = 4'd4; wr0_d = 32'h22;
        rd1_v = 1'b1; rd1_a = 4'd5;
        #1;
        chk("ram_resp0", 64'(rsp0_v), 64'd1);
        chk("ram_data0", 64'(rsp0_d), 64'h11);
        tick();
        wr0_v = 1'b0; rd1_v = 1'b0;
        rd0_v = 1'b1; rd0_a = 4'd4;
        #1;
        chk("miss_resp1", 64'(rsp1_v), 64'd1);
        chk("miss_data1", 64'(rsp1_d), 64'h5050);

        // Flush with a read accepted in the same cycle
        tick();
        flush = 1'b1;
        #1;
        chk("flush_rd0_ready", 64'(rd0_r), 64'd1);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("after_wr_data0", 64'(rsp0_d), 64'h22);
        tick();
        flush = 1'b0; rd0_v = 1'b0;
        #1;
        chk("flush_resp0", 64'(rsp0_v), 64'd1);
        chk("flush_data0", 64'(rsp0_d), 64'h22);
        chk("flush_busy_hi", 64'(busy), 64'd1);
        chk("flush_rd0_ready_lo", 64'(rd0_r), 64'd0);
        clear_seq(6);

        tick();
        rd0_v = 1'b1; rd0_a = 4'd4;
        rd1_v = 1'b1; rd1_a = 4'd7;
        tick();
        rd0_v = 1'b0; rd1_v = 1'b0;
        #1;
        chk("cleared_data0", 64'(rsp0_d), 64'(INIT));
        chk("cleared_data1", 64'(rsp1_d), 64'(INIT));

        // Asynchronous reset in the middle of a clear
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (6) tick();
        #2;
        chk("midclr_we_pre", 64'(ram_we), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd1);
        chk("arst_we", 64'(ram_we), 64'd0);
        chk("arst_waddr", 64'(ram_wa), 64'd0);
        chk("arst_wdata", 64'(ram_wd), 64'd0);
        chk("arst_resp0", 64'(rsp0_v), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_seq(-1);

        tick();
        rd1_v = 1'b1; rd1_a = 4'd5;
        tick();
        rd1_v = 1'b0;
        #1;
        chk("final_resp1", 64'(rsp1_v), 64'd1);
        chk("final_data1", 64'(rsp1_d), 64'(INIT));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/three_port_ram_ctrl.md
# three_port_ram_ctrl

Controller for the one-write / two-read synchronous RAM (read latency 1, read-first on same-address collision). It clears the RAM after reset or on request. It round-robin arbitrates two write requesters onto the single write port. It serves two read clients with valid/ready request handshakes and one-cycle responses. It forwards same-cycle write data so that clients see write-first semantics.

## Interface
- ADDR_WIDTH, 10, RAM address width
- DATA_DEPTH, 1024, number of RAM words, ≤ 2**ADDR_WIDTH
- DATA_WIDTH, 32, word width
- INIT_VALUE, '0, word written to every address during clear

- Clk_CI  in  1  clock, rising edge
- Rst_RBI  in  1  reset, asynchronous, active-low
- FlushReq_SI  in  1  pulse: re-clear whole RAM
- Busy_SO  out  1  high while in INIT or CLEAR
- Wr0Valid_SI / Wr1Valid_SI  in  1  write request valid, requester 0/1
- Wr0Ready_SO / Wr1Ready_SO  out  1  write grant, requester 0/1
- Wr0Addr_DI / Wr1Addr_DI  in  ADDR_WIDTH  write address
- Wr0Data_DI / Wr1Data_DI  in  DATA_WIDTH  write data
- Rd0Valid_SI / Rd1Valid_SI  in  1  read request valid, client 0/1
- Rd0Ready_SO / Rd1Ready_SO  out  1  read request accepted
- Rd0Addr_DI / Rd1Addr_DI  in  ADDR_WIDTH  read address
- Rd0RespValid_SO / Rd1RespValid_SO  out  1  response valid
- Rd0Data_DO / Rd1Data_DO  out  DATA_WIDTH  response data
- RamWrEn_SO  out  1  RAM write enable
- RamWrAddr_DO  out  ADDR_WIDTH  RAM write address
- RamWrData_DO  out  DATA_WIDTH  RAM write data
- RamRdAddr0_DO / RamRdAddr1_DO  out  ADDR_WIDTH  RAM read addresses
- RamRdData0_DI / RamRdData1_DI  in  DATA_WIDTH  RAM read data, valid one cycle after address

## Operation
- FSM states: INIT, CLEAR, RUN. Reset state is INIT.
- INIT: one cycle, no RAM write. Next state is CLEAR with ClrCnt=0.
- CLEAR: RamWrEn_SO=1, RamWrAddr_DO=ClrCnt, RamWrData_DO=INIT_VALUE. ClrCnt increments each cycle.
  - When ClrCnt==DATA_DEPTH-1, the write to that address happens and the next state is RUN.
  - FlushReq_SI is ignored in CLEAR; the clear is not restarted.
- RUN, writes: one grant per cycle.
  - Only one requester valid: it is granted.
  - Both valid: the requester pointed to by RrPtr is granted.
  - After any grant to requester i, RrPtr becomes 1-i.
  - WrXReady_SO = RUN && grantX. Ready depends combinationally on valid.
  - A granted write drives RamWrEn_SO=1 with that requester's address and data in the same cycle.
- RUN, reads: RdXReady_SO=1 in every RUN cycle. RamRdAddrX_DO=RdXAddr_DI combinationally.
- Response: a handshake in cycle t gives RdXRespValid_SO=1 in t+1 with RdXData_DO.
  - If a write to the same address is granted in cycle t, RdXData_DO in t+1 is the write data.
  - Otherwise RdXData_DO is RamRdDataX_DI.
  - Implemented with a per-port registered forward flag and data.
- Both read ports may hit the same address as the write; both ports forward.
- FlushReq_SI=1 in RUN: that cycle is still a normal RUN cycle, with grants and reads served. Next state is INIT.
- In INIT and CLEAR, all WrXReady_SO and RdXReady_SO are 0. Response valids follow the previous cycle's handshakes, so a read accepted in the last RUN cycle still responds.
- Undriven RAM outputs are 0 whenever not in use: RamWrAddr_DO and RamWrData_DO when no write, and RamRdAddrX_DO outside RUN.

## Timing
- Reset values:
  - State=INIT, ClrCnt=0, RrPtr=0.
  - Busy_SO=1.
  - All Ready, RespValid and RamWrEn outputs are 0. All data and address outputs are 0.
- Clear time: DATA_DEPTH+1 cycles from reset release to the first RUN cycle, where Busy_SO falls.
- Read latency: exactly 1 cycle. No back-pressure on responses.
- Write is committed in the grant cycle and visible to a read issued in that same cycle via forwarding.
- Reset asserted mid-clear or mid-RUN returns immediately to INIT. Pending responses are dropped (RespValid=0).
- ClrCnt is ADDR_WIDTH bits wide. It never wraps, because the terminal compare is at DATA_DEPTH-1.

## Test plan
- Reset release with DATA_DEPTH=16: Busy_SO=1 for 17 cycles, with RamWrEn_SO=1 on addresses 0..15 carrying INIT_VALUE. Then Busy_SO=0 and both read Ready=1.
- Both writers valid continuously, addresses 3 and 5: grants alternate 0,1,0,1. Each grant cycle shows RamWrEn_SO=1 with the matching address and data.
- Write 0xDEADBEEF to address 7 and Rd0 and Rd1 read address 7 in the same cycle: next cycle both RespValid=1 with data 0xDEADBEEF (forwarded).
- Read address 4 holding 0x11 with no colliding write: next cycle RespValid=1 and data 0x11. Read again one cycle after writing 0x22 to address 4: data 0x22.
- FlushReq_SI pulse in RUN with a read accepted in that cycle: the response is still delivered next cycle. Then Busy_SO=1, Ready=0, and a full clear runs. A later read of any address returns INIT_VALUE.
- Rst_RBI asserted midway through CLEAR: outputs return to their reset values asynchronously, and the clear restarts from address 0 after release.
